// File: rtl/pio_pkg.sv
// Shared constants for the button/LED PIO: register word addresses, ID magic and bus width.
package pio_pkg;

  localparam int DATA_W = 32;

  localparam logic [2:0] ADDR_STATE   = 3'd0;
  localparam logic [2:0] ADDR_EDGE    = 3'd1;
  localparam logic [2:0] ADDR_MASK    = 3'd2;
  localparam logic [2:0] ADDR_LED     = 3'd3;
  localparam logic [2:0] ADDR_LED_SET = 3'd4;
  localparam logic [2:0] ADDR_LED_CLR = 3'd5;
  localparam logic [2:0] ADDR_BLINK   = 3'd6;
  localparam logic [2:0] ADDR_ID      = 3'd7;

  localparam logic [7:0] ID_MAGIC = 8'hB1;

endpackage

// File: rtl/button_debounce.sv
// One button channel: two-flop synchroniser, polarity normalisation and a
// stability counter that only lets the debounced state follow a steady input.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin,
  output logic state,
  output logic rise
);

  localparam int              CNT_W      = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic            IDLE_LEVEL = ACTIVE_LOW;

  logic             sync_a;
  logic             sync_b;
  logic             pressed;
  logic             settled;
  logic [CNT_W-1:0] cnt;

  // Sync flops reset to the released pin level so reset never looks like a press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_a <= IDLE_LEVEL;
      sync_b <= IDLE_LEVEL;
    end else begin
      sync_a <= pin;
      sync_b <= sync_a;
    end
  end

  assign pressed = sync_b ^ IDLE_LEVEL;
  assign settled = (pressed != state) && (cnt == CNT_LAST);
  assign rise    = settled && pressed;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      state <= 1'b0;
    end else if (pressed == state) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      state <= pressed;
      cnt   <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/avalon_button_led_pio.sv
// Avalon-MM button/LED PIO with debounce, press capture, maskable irq and atomic LED set/clear.
// Define BUTTON_PIO_BLINK_EN to add the BLINK register and a 24-bit blink prescaler.
module avalon_button_led_pio
  import pio_pkg::*;
#(
  parameter int NUM_BUTTONS     = 2,
  parameter int NUM_LEDS        = 10,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int BTN_ACTIVE_LOW  = 1
) (
  input  logic                   clk_clk,
  input  logic                   reset_reset_n,
  input  logic [2:0]             avs_address,
  input  logic                   avs_read,
  input  logic                   avs_write,
  input  logic [DATA_W-1:0]      avs_writedata,
  output logic [DATA_W-1:0]      avs_readdata,
  output logic                   irq,
  input  logic [NUM_BUTTONS-1:0] button_export,
  output logic [NUM_LEDS-1:0]    led_export
);

  logic [NUM_BUTTONS-1:0] btn_state;
  logic [NUM_BUTTONS-1:0] btn_rise;
  logic [NUM_BUTTONS-1:0] edge_q;
  logic [NUM_BUTTONS-1:0] mask_q;
  logic [NUM_LEDS-1:0]    led_q;
  logic [NUM_BUTTONS-1:0] wdata_btn;
  logic [NUM_LEDS-1:0]    wdata_led;
  logic [DATA_W-1:0]      rd_mux;
  logic [DATA_W-1:0]      id_word;

  // Only the low bits of writedata matter; the reduction keeps the rest visibly consumed.
  wire unused_wdata = ^avs_writedata;

  assign wdata_btn = avs_writedata[NUM_BUTTONS-1:0];
  assign wdata_led = avs_writedata[NUM_LEDS-1:0];
  assign id_word   = {ID_MAGIC, 8'(NUM_LEDS), 8'(NUM_BUTTONS), 8'h00};

  for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_btn
    button_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .ACTIVE_LOW     (BTN_ACTIVE_LOW != 0)
    ) u_debounce (
      .clk  (clk_clk),
      .rst_n(reset_reset_n),
      .pin  (button_export[i]),
      .state(btn_state[i]),
      .rise (btn_rise[i])
    );
  end

  // A press arriving in the same cycle as a write-1-clear keeps its bit set.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      edge_q <= '0;
      mask_q <= '0;
      irq    <= 1'b0;
    end else begin
      irq <= |(edge_q & mask_q);
      if (avs_write && avs_address == ADDR_MASK) mask_q <= wdata_btn;
      if (avs_write && avs_address == ADDR_EDGE) edge_q <= (edge_q & ~wdata_btn) | btn_rise;
      else                                       edge_q <= edge_q | btn_rise;
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      led_q <= '0;
    end else if (avs_write) begin
      case (avs_address)
        ADDR_LED:     led_q <= wdata_led;
        ADDR_LED_SET: led_q <= led_q | wdata_led;
        ADDR_LED_CLR: led_q <= led_q & ~wdata_led;
        default:      led_q <= led_q;
      endcase
    end
  end

`ifdef BUTTON_PIO_BLINK_EN
  logic [NUM_LEDS-1:0] blink_q;
  logic [23:0]         prescale;
  logic                phase;

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      blink_q  <= '0;
      prescale <= '0;
      phase    <= 1'b0;
    end else begin
      prescale <= prescale + 24'd1;
      phase    <= phase ^ (&prescale);
      if (avs_write && avs_address == ADDR_BLINK) blink_q <= wdata_led;
    end
  end

  assign led_export = led_q & ~(blink_q & ~{NUM_LEDS{phase}});
`else
  assign led_export = led_q;
`endif

  always_comb begin
    rd_mux = '0;
    case (avs_address)
      ADDR_STATE: rd_mux = DATA_W'(btn_state);
      ADDR_EDGE:  rd_mux = DATA_W'(edge_q);
      ADDR_MASK:  rd_mux = DATA_W'(mask_q);
      ADDR_LED:   rd_mux = DATA_W'(led_q);
`ifdef BUTTON_PIO_BLINK_EN
      ADDR_BLINK: rd_mux = DATA_W'(blink_q);
`endif
      ADDR_ID:    rd_mux = id_word;
      default:    rd_mux = '0;
    endcase
  end

  // Registered read path gives fixed latency 1 and returns pre-write contents.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n)  avs_readdata <= '0;
    else if (avs_read)   avs_readdata <= rd_mux;
    else                 avs_readdata <= '0;
  end

endmodule

// File: tb/tb_avalon_button_led_pio.sv
// Self-checking bench: directed register/debounce scenarios plus random pins and bus
// traffic, compared every cycle against a window-based behavioural model.
module tb_avalon_button_led_pio;

  localparam int NB = 2;
  localparam int NL = 10;
  localparam int DB = 4;

  logic          clk_clk = 1'b0;
  logic          reset_reset_n;
  logic [2:0]    avs_address;
  logic          avs_read;
  logic          avs_write;
  logic [31:0]   avs_writedata;
  logic [31:0]   avs_readdata;
  logic          irq;
  logic [NB-1:0] button_export;
  logic [NL-1:0] led_export;

  int compared   = 0;
  int mismatched = 0;

  logic [NB-1:0] m_state, m_edge, m_mask;
  logic [NL-1:0] m_led, m_blink;
  logic          m_irq;
  logic [NB-1:0] pin_log[$];

  always #5 clk_clk = ~clk_clk;

  avalon_button_led_pio #(
    .NUM_BUTTONS(NB), .NUM_LEDS(NL), .DEBOUNCE_CYCLES(DB), .BTN_ACTIVE_LOW(1)
  ) dut (
    .clk_clk(clk_clk), .reset_reset_n(reset_reset_n),
    .avs_address(avs_address), .avs_read(avs_read), .avs_write(avs_write),
    .avs_writedata(avs_writedata), .avs_readdata(avs_readdata), .irq(irq),
    .button_export(button_export), .led_export(led_export)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [2:0] a);
    case (a)
      3'd0: return 32'(m_state);
      3'd1: return 32'(m_edge);
      3'd2: return 32'(m_mask);
      3'd3: return 32'(m_led);
`ifdef BUTTON_PIO_BLINK_EN
      3'd6: return 32'(m_blink);
`endif
      3'd7: return 32'hB10A0200;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [NL-1:0] model_leds();
`ifdef BUTTON_PIO_BLINK_EN
    return m_led & ~m_blink;
`else
    return m_led;
`endif
  endfunction

  // Pin history starts at the released level, as if the pins had been idle forever.
  task automatic model_reset();
    m_state = '0; m_edge = '0; m_mask = '0; m_led = '0; m_blink = '0; m_irq = 1'b0;
    pin_log.delete();
    repeat (7) pin_log.push_back('1);
  endtask

  task automatic do_reset();
    avs_read = 1'b0; avs_write = 1'b0; avs_address = '0; avs_writedata = '0;
    reset_reset_n = 1'b0;
    model_reset();
    #1;
    checkOutput("reset_led", 32'(led_export), 32'h0);
    checkOutput("reset_irq", 32'(irq), 32'h0);
    checkOutput("reset_rd", avs_readdata, 32'h0);
    repeat (2) @(posedge clk_clk);
    #1;
    reset_reset_n = 1'b1;
  endtask

  // One clock: drive inputs, advance the model over the edge, then check outputs.
  // A button flips once its synchronised level (two edges late) has disagreed
  // with the debounced state on DB consecutive edges.
  task automatic applyStimulus(input logic [NB-1:0] pins, input logic rd, input logic wr,
                               input logic [2:0] addr, input logic [31:0] wdata);
    logic [31:0]   rd_exp;
    logic          irq_new;
    logic [NB-1:0] rise;
    logic [NB-1:0] sample;
    bit            all_differ;
    int            sz;
    button_export = pins; avs_read = rd; avs_write = wr;
    avs_address = addr; avs_writedata = wdata;
    @(posedge clk_clk);
    rd_exp  = model_read(addr);
    irq_new = |(m_edge & m_mask);
    pin_log.push_back(pins);
    if (pin_log.size() > 8) void'(pin_log.pop_front());
    sz   = pin_log.size();
    rise = '0;
    for (int b = 0; b < NB; b++) begin
      all_differ = 1'b1;
      for (int k = 3; k < 3 + DB; k++) begin
        sample = pin_log[sz - k];
        if (~sample[b] == m_state[b]) all_differ = 1'b0;
      end
      if (all_differ) begin
        if (!m_state[b]) rise[b] = 1'b1;
        m_state[b] = ~m_state[b];
      end
    end
    if (wr && addr == 3'd1) m_edge = (m_edge & ~wdata[NB-1:0]) | rise;
    else                    m_edge = m_edge | rise;
    if (wr) begin
      case (addr)
        3'd2: m_mask = wdata[NB-1:0];
        3'd3: m_led  = wdata[NL-1:0];
        3'd4: m_led  = m_led | wdata[NL-1:0];
        3'd5: m_led  = m_led & ~wdata[NL-1:0];
`ifdef BUTTON_PIO_BLINK_EN
        3'd6: m_blink = wdata[NL-1:0];
`endif
        default: ;
      endcase
    end
    m_irq = irq_new;
    #1;
    checkOutput("led_export", 32'(led_export), 32'(model_leds()));
    checkOutput("irq", 32'(irq), 32'(m_irq));
    if (rd) checkOutput($sformatf("read_addr%0d", addr), avs_readdata, rd_exp);
  endtask

  initial begin
    logic [NB-1:0] pins;
    int            first_edge;

    reset_reset_n = 1'b1;
    button_export = '1;
    #1;
    do_reset();

    applyStimulus(2'b11, 1, 0, 3'd7, 0);
    checkOutput("id_const", avs_readdata, 32'hB10A0200);
    for (int a = 0; a < 4; a++) applyStimulus(2'b11, 1, 0, 3'(a), 0);

    // Steady press on button 0, then a 3-cycle glitch on button 1.
    for (int i = 0; i < 9; i++) applyStimulus(2'b10, 1, 0, 3'd1, 0);
    for (int i = 0; i < 3; i++) applyStimulus(2'b00, 1, 0, 3'd0, 0);
    for (int i = 0; i < 8; i++) applyStimulus(2'b10, 1, 0, 3'd0, 0);
    checkOutput("state_b0_only", avs_readdata, 32'h1);
    applyStimulus(2'b10, 1, 0, 3'd1, 0);
    checkOutput("edge_b0_only", avs_readdata, 32'h1);

    // Mask, clear, release, then a clear landing on the press edge.
    applyStimulus(2'b10, 0, 1, 3'd2, 32'h1);
    applyStimulus(2'b10, 0, 0, 3'd0, 0);
    checkOutput("irq_masked_edge", 32'(irq), 32'h1);
    applyStimulus(2'b10, 0, 1, 3'd1, 32'h1);
    applyStimulus(2'b11, 0, 0, 3'd0, 0);
    checkOutput("irq_after_clear", 32'(irq), 32'h0);
    for (int i = 0; i < 8; i++) applyStimulus(2'b11, 1, 0, 3'd0, 0);
    for (int i = 0; i < 5; i++) applyStimulus(2'b10, 0, 0, 3'd0, 0);
    applyStimulus(2'b10, 0, 1, 3'd1, 32'h1);
    applyStimulus(2'b10, 1, 0, 3'd1, 0);
    checkOutput("edge_set_wins", avs_readdata, 32'h1);

    // LED register and atomic set/clear.
    applyStimulus(2'b11, 0, 1, 3'd3, 32'h0F0);
    applyStimulus(2'b11, 0, 1, 3'd4, 32'h003);
    applyStimulus(2'b11, 0, 1, 3'd5, 32'h010);
    checkOutput("led_set_clr", 32'(led_export), 32'h0E3);
    applyStimulus(2'b11, 0, 1, 3'd3, 32'hFFFFFFFF);
    applyStimulus(2'b11, 1, 0, 3'd3, 0);
    checkOutput("led_all_ones", avs_readdata, 32'h3FF);
    applyStimulus(2'b11, 1, 1, 3'd6, 32'h3FF);
    applyStimulus(2'b11, 1, 0, 3'd6, 0);

    // Reset in the middle of a debounce while the pin stays pressed.
    for (int i = 0; i < 3; i++) applyStimulus(2'b10, 0, 0, 3'd0, 0);
    do_reset();
    first_edge = 0;
    for (int i = 1; i <= 10; i++) begin
      applyStimulus(2'b10, 1, 0, 3'd1, 0);
      if (first_edge == 0 && avs_readdata[0]) first_edge = i;
    end
    checkOutput("reset_edge_cycle", 32'(first_edge), 32'd7);
    applyStimulus(2'b10, 0, 1, 3'd1, 32'h3);
    for (int i = 0; i < 8; i++) applyStimulus(2'b10, 1, 0, 3'd1, 0);
    checkOutput("edge_captured_once", avs_readdata, 32'h0);

    // Random pin activity and bus traffic against the model.
    pins = 2'b11;
    for (int i = 0; i < 3000; i++) begin
      for (int b = 0; b < NB; b++)
        if ($urandom_range(0, 5) == 0) pins[b] = ~pins[b];
      applyStimulus(pins, 1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0),
                    3'($urandom_range(0, 7)),
                    ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFF : $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
